adder: RTL and testbench

//  AXI4-Lite memory-mapped slave wrapping a DATA_WIDTH-bit adder peripheral.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_core.sv | 24 ++
 rtl/adder.sv | 180 ++++++++++++++++++
 tb/tb_adder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the adder AXI4-Lite peripheral: register word indices,
// response codes and channel state types.
package adder_pkg;

  localparam logic [31:0] WORD_A      = 32'd0;
  localparam logic [31:0] WORD_B      = 32'd1;
  localparam logic [31:0] WORD_SUM    = 32'd2;
  localparam logic [31:0] WORD_STATUS = 32'd3;
  localparam logic [31:0] WORD_CTRL   = 32'd4;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rd_state_t;

endpackage

// File: rtl/adder_core.sv
// Combinational arithmetic core: add, or subtract when op=1.
// The carry output holds the add carry-out, or the borrow (a < b) when subtracting.
module adder_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  op,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry
);

  logic [DATA_WIDTH:0] wide;

  // The extra MSB of the widened difference is the unsigned borrow.
  always_comb begin
    if (op) wide = {1'b0, a} - {1'b0, b};
    else    wide = {1'b0, a} + {1'b0, b};
  end

  assign sum   = wide[DATA_WIDTH-1:0];
  assign carry = wide[DATA_WIDTH];

endmodule

// File: rtl/adder.sv
// AXI4-Lite slave around adder_core: A/B operand registers, read-only SUM/STATUS.
// ADDER_SUB_EN adds CTRL at 0x10 (bit0 selects subtraction).
//   state    | meaning
//   W_IDLE   | waiting for awvalid && wvalid
//   W_ACCEPT | awready/wready high, write lands this edge
//   W_RESP   | bvalid high until bready
//   R_IDLE   | waiting for arvalid
//   R_ACCEPT | arready high, rdata sampled this edge
//   R_DATA   | rvalid high until rready
module adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic                    s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic                    s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_WIDTH-1:0] a_reg, b_reg, sum;
  logic                  carry, op;
  logic [31:0]           wr_word, rd_word;
  logic                  wr_ok, rd_err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr_bits;

  assign wr_word          = 32'(s1_axi_awaddr[ADDR_WIDTH-1:2]);
  assign rd_word          = 32'(s1_axi_araddr[ADDR_WIDTH-1:2]);
  assign unused_addr_bits = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

`ifdef ADDER_SUB_EN
  logic op_reg;
  assign op = op_reg;
`else
  assign op = 1'b0;
`endif

  adder_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .a     (a_reg),
    .b     (b_reg),
    .op    (op),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Ready is registered one cycle after valid so no output follows an input during reset.
  always_comb begin
    wr_next        = wr_state;
    s1_axi_awready = 1'b0;
    s1_axi_wready  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE:   if (s1_axi_awvalid && s1_axi_wvalid) wr_next = W_ACCEPT;
      W_ACCEPT: begin
        s1_axi_awready = 1'b1;
        s1_axi_wready  = 1'b1;
        wr_next        = W_RESP;
      end
      W_RESP: begin
        s1_axi_bvalid = 1'b1;
        if (s1_axi_bready) wr_next = W_IDLE;
      end
      default:  wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next        = rd_state;
    s1_axi_arready = 1'b0;
    s1_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE:   if (s1_axi_arvalid) rd_next = R_ACCEPT;
      R_ACCEPT: begin
        s1_axi_arready = 1'b1;
        rd_next        = R_DATA;
      end
      R_DATA: begin
        s1_axi_rvalid = 1'b1;
        if (s1_axi_rready) rd_next = R_IDLE;
      end
      default:  rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_ok = 1'b0;
    case (wr_word)
      WORD_A, WORD_B: wr_ok = 1'b1;
`ifdef ADDER_SUB_EN
      WORD_CTRL:      wr_ok = 1'b1;
`else
      WORD_CTRL:      wr_ok = 1'b0;
`endif
      default:        wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      a_reg        <= '0;
      b_reg        <= '0;
      s1_axi_bresp <= RESP_OKAY;
`ifdef ADDER_SUB_EN
      op_reg       <= 1'b0;
`endif
    end else if (wr_state == W_ACCEPT) begin
      s1_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s1_axi_wstrb[i]) begin
          if (wr_word == WORD_A) a_reg[i*8 +: 8] <= s1_axi_wdata[i*8 +: 8];
          if (wr_word == WORD_B) b_reg[i*8 +: 8] <= s1_axi_wdata[i*8 +: 8];
        end
      end
`ifdef ADDER_SUB_EN
      if (wr_word == WORD_CTRL && s1_axi_wstrb[0]) op_reg <= s1_axi_wdata[0];
`endif
    end
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_word)
      WORD_A:      rd_val = a_reg;
      WORD_B:      rd_val = b_reg;
      WORD_SUM:    rd_val = sum;
      WORD_STATUS: rd_val = DATA_WIDTH'(carry);
`ifdef ADDER_SUB_EN
      WORD_CTRL:   rd_val = DATA_WIDTH'(op_reg);
`else
      WORD_CTRL:   rd_err = 1'b1;
`endif
      default:     rd_err = 1'b1;
    endcase
  end

  // Sampling at the accept edge returns pre-write values for a coincident write.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      s1_axi_rdata <= '0;
      s1_axi_rresp <= RESP_OKAY;
    end else if (rd_state == R_ACCEPT) begin
      s1_axi_rdata <= rd_val;
      s1_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed AXI4-Lite steps then random traffic
// compared against a register-level arithmetic model.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bresp, bvalid, arready, rresp, rvalid;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_a = '0, m_b = '0;
  logic        m_op = 1'b0;

  always #5 clk = ~clk;

  adder dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (rst_n),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_read(input logic [7:0] addr, output logic [31:0] d, output logic r);
    int w;
    longint unsigned s;
    w = int'(addr >> 2);
    d = '0;
    r = 1'b0;
    s = longint'(m_a) + longint'(m_b);
    case (w)
      0: d = m_a;
      1: d = m_b;
      2: d = m_op ? (m_a - m_b) : s[31:0];
      3: d = m_op ? {31'b0, (m_a < m_b)} : {31'b0, s[32]};
`ifdef ADDER_SUB_EN
      4: d = {31'b0, m_op};
`endif
      default: r = 1'b1;
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic r);
    int w;
    w = int'(addr >> 2);
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (strb[i] && w == 0) m_a[i*8 +: 8] = data[i*8 +: 8];
      if (strb[i] && w == 1) m_b[i*8 +: 8] = data[i*8 +: 8];
    end
    if (w == 0 || w == 1) r = 1'b0;
`ifdef ADDER_SUB_EN
    if (w == 4) begin
      r = 1'b0;
      if (strb[0]) m_op = data[0];
    end
`endif
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_wait", 32'(n < 50), 32'd1);
    check("w_ready_with_aw", 32'(wready), 32'(awready));
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("b_wait", 32'(n < 50), 32'd1);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] d, output logic resp);
    int n;
    araddr = addr; arvalid = 1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("r_wait", 32'(n < 50), 32'd1);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic wr_dir(input string tag, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic exp_resp);
    logic r, mr;
    model_write(addr, data, strb, mr);
    do_write(addr, data, strb, r);
    check({tag, "_bresp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic rd_dir(input string tag, input logic [7:0] addr, input logic [31:0] exp_d,
                        input logic exp_resp);
    logic [31:0] d;
    logic r;
    do_read(addr, d, r);
    check({tag, "_rdata"}, d, exp_d);
    check({tag, "_rresp"}, 32'(r), 32'(exp_resp));
  endtask

  initial begin
    logic [31:0] d, ed, pre;
    logic r, er;
    int n;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'({awready, wready, arready}), 0);
    check("post_rst_valid", 32'({bvalid, rvalid}), 0);
    check("post_rst_resp", 32'({bresp, rresp}), 0);
    rd_dir("t1_sum", 8'h08, 32'd0, 1'b0);

    // basic add
    wr_dir("t2_wa", 8'h00, 32'd23, 4'hF, 1'b0);
    wr_dir("t2_wb", 8'h04, 32'd30, 4'hF, 1'b0);
    rd_dir("t2_sum", 8'h08, 32'd53, 1'b0);
    rd_dir("t2_status", 8'h0C, 32'd0, 1'b0);
    rd_dir("t2_a", 8'h00, 32'd23, 1'b0);

    // carry out
    wr_dir("t3_wa", 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr_dir("t3_wb", 8'h04, 32'd1, 4'hF, 1'b0);
    rd_dir("t3_sum", 8'h08, 32'd0, 1'b0);
    rd_dir("t3_carry", 8'h0C, 32'd1, 1'b0);

    // partial strobe
    wr_dir("t4_wa", 8'h00, 32'h1122_3344, 4'hF, 1'b0);
    wr_dir("t4_wpart", 8'h00, 32'hAABB_CCDD, 4'h1, 1'b0);
    rd_dir("t4_a", 8'h00, 32'h1122_33DD, 1'b0);
    wr_dir("t4_wpart2", 8'h03, 32'hAABB_CCDD, 4'hA, 1'b0);
    rd_dir("t4_a2", 8'h00, 32'hAA22_CCDD, 1'b0);

    // read-only and unmapped
    wr_dir("t5_wsum", 8'h08, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr_dir("t5_wstat", 8'h0C, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr_dir("t5_wunmap", 8'h20, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd_dir("t5_a", 8'h00, 32'hAA22_CCDD, 1'b0);
    rd_dir("t5_b", 8'h04, 32'd1, 1'b0);
    rd_dir("t5_r20", 8'h20, 32'd0, 1'b1);
`ifdef ADDER_SUB_EN
    wr_dir("sub_op", 8'h10, 32'd1, 4'hF, 1'b0);
    wr_dir("sub_wa", 8'h00, 32'd5, 4'hF, 1'b0);
    wr_dir("sub_wb", 8'h04, 32'd7, 4'hF, 1'b0);
    rd_dir("sub_diff", 8'h08, 32'hFFFF_FFFE, 1'b0);
    rd_dir("sub_borrow", 8'h0C, 32'd1, 1'b0);
    rd_dir("sub_ctrl", 8'h10, 32'd1, 1'b0);
    wr_dir("sub_op0", 8'h10, 32'd0, 4'hF, 1'b0);
`else
    wr_dir("t5_wctrl", 8'h10, 32'd1, 4'hF, 1'b1);
    rd_dir("t5_r10", 8'h10, 32'd0, 1'b1);
`endif

    // write response backpressure, second write held off
    model_write(8'h04, 32'h55, 4'hF, er);
    awaddr = 8'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_aw_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    awaddr = 8'h00; wdata = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t6_bvalid_held", 32'({bvalid, bresp}), 32'({1'b1, er}));
      check("t6_no_accept", 32'({awready, wready}), 0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("t6_bvalid_drop", 32'(bvalid), 0);
    wr_dir("t6_w2", 8'h00, 32'h99, 4'hF, 1'b0);

    // read data backpressure with a write changing the sum underneath
    model_read(8'h08, ed, er);
    araddr = 8'h08; arvalid = 1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_ar_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    araddr = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t6_rvalid_held", 32'(rvalid), 1);
      check("t6_rdata_held", rdata, ed);
      check("t6_no_ar", 32'(arready), 0);
    end
    wr_dir("t6_wa_mid", 8'h00, 32'h1234_5678, 4'hF, 1'b0);
    check("t6_rdata_after_w", rdata, ed);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("t6_rvalid_drop", 32'(rvalid), 0);
    rd_dir("t6_rd2", 8'h00, 32'h1234_5678, 1'b0);

    // coincident read and write: read sees pre-write values
    model_read(8'h08, pre, er);
    awaddr = 8'h04; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h08; arvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check("same_aw_wait", 32'(n < 50), 32'd1);
    check("same_ar_together", 32'(arready), 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_valids", 32'({bvalid, rvalid}), 32'h3);
    check("same_rdata_pre", rdata, pre);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    model_write(8'h04, 32'h0F0F_0F0F, 4'hF, er);
    model_read(8'h08, ed, er);
    rd_dir("same_post_sum", 8'h08, ed, er);

    // random traffic against the model
    for (int k = 0; k < 60; k++) begin
      logic [7:0] addr;
      addr = 8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] dat;
        logic [3:0] st;
        dat = $urandom;
        st = 4'($urandom_range(0, 15));
        model_write(addr, dat, st, er);
        do_write(addr, dat, st, r);
        check("rand_bresp", 32'(r), 32'(er));
      end else begin
        model_read(addr, ed, er);
        do_read(addr, d, r);
        check("rand_rdata", d, ed);
        check("rand_rresp", 32'(r), 32'(er));
      end
    end

    // reset in the middle of pending responses
    awaddr = 8'h00; wdata = 32'hCAFE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 8'h00; arvalid = 1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("mid_pending", 32'({bvalid, rvalid}), 32'h3);
    rst_n = 0;
    #1;
    check("mid_rst_valid", 32'({bvalid, rvalid, awready, arready}), 0);
    check("mid_rst_rdata", rdata, 0);
    m_a = '0; m_b = '0; m_op = 1'b0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    rd_dir("mid_a_cleared", 8'h00, 32'd0, 1'b0);
    rd_dir("mid_sum_cleared", 8'h08, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
